// File: rtl/ref_clk_select.sv
// ref_clk_select: counts reference edges per gate window, qualifies channels, and picks the best reference with holdoff.
// Define REF_CLK_SELECT_FORCE_EN to add the force_en/force_sel manual override.
module ref_clk_select #(
    parameter int CH_COUNT        = 2,
    parameter int GATE_CYCLES     = 25000,
    parameter int CNT_WIDTH       = 16,
    parameter int COUNT_MIN       = 990,
    parameter int COUNT_MAX       = 1010,
    parameter int QUAL_WINDOWS    = 4,
    parameter int HOLDOFF_WINDOWS = 2,
    localparam int SW = CH_COUNT > 1 ? $clog2(CH_COUNT) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CH_COUNT-1:0]           ref_in,
`ifdef REF_CLK_SELECT_FORCE_EN
    input  logic                          force_en,
    input  logic [SW-1:0]                 force_sel,
`endif
    output logic [CH_COUNT-1:0]           ch_valid,
    output logic [CH_COUNT*CNT_WIDTH-1:0] ref_count,
    output logic [SW-1:0]                 sel,
    output logic                          sel_valid,
    output logic                          switch_pulse,
    output logic                          window_pulse
);
    localparam int GW = GATE_CYCLES > 1 ? $clog2(GATE_CYCLES) : 1;
    localparam int QW = QUAL_WINDOWS > 0 ? $clog2(QUAL_WINDOWS + 1) : 1;
    localparam int HW = HOLDOFF_WINDOWS > 0 ? $clog2(HOLDOFF_WINDOWS + 1) : 1;
    localparam int NP = 1 << SW;
    localparam logic [CNT_WIDTH-1:0] CNT_SAT = '1;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HOLD, S_FORCE} state_t;

    logic [CH_COUNT-1:0]           s1_q, s2_q, hist_q, rise;
    logic [GW-1:0]                 gate_q;
    logic                          close, win_q, eval_q;
    logic [CNT_WIDTH-1:0]          cnt_q [CH_COUNT];
    logic [CNT_WIDTH-1:0]          cnt_d [CH_COUNT];
    logic [CNT_WIDTH-1:0]          cnt_sum [CH_COUNT];
    logic [CNT_WIDTH-1:0]          win_cnt [CH_COUNT];
    logic [CH_COUNT*CNT_WIDTH-1:0] ref_count_q, ref_count_d;
    logic [QW-1:0]                 qual_q [CH_COUNT];
    logic [QW-1:0]                 qual_d [CH_COUNT];
    logic [CH_COUNT-1:0]           in_range, ch_valid_q, ch_valid_d;
    state_t                        state_q, state_d;
    logic [SW-1:0]                 sel_q, sel_d, best;
    logic                          sel_valid_q, sel_valid_d, switch_q, switch_d;
    logic [HW-1:0]                 hold_q, hold_d;
    logic [NP-1:0]                 valid_pad;
    logic                          any, lost;

    // Two synchroniser stages plus a history flop per channel
    assign rise  = s2_q & ~hist_q;
    assign close = gate_q == GW'(GATE_CYCLES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            hist_q <= '0;
            gate_q <= '0;
            win_q  <= 1'b0;
            eval_q <= 1'b0;
        end else begin
            s1_q   <= ref_in;
            s2_q   <= s1_q;
            hist_q <= s2_q;
            gate_q <= close ? '0 : gate_q + GW'(1);
            win_q  <= close;
            eval_q <= win_q;
        end
    end

    always_comb begin
        ref_count_d = ref_count_q;
        for (int i = 0; i < CH_COUNT; i++) begin
            cnt_sum[i] = cnt_q[i] == CNT_SAT ? CNT_SAT : cnt_q[i] + CNT_WIDTH'(rise[i]);
            cnt_d[i] = close ? '0 : cnt_sum[i];
            if (close) ref_count_d[i*CNT_WIDTH +: CNT_WIDTH] = cnt_sum[i];
        end
    end

    // A saturated count is excluded even if COUNT_MAX reaches the counter ceiling
    always_comb begin
        ch_valid_d = ch_valid_q;
        in_range = '0;
        for (int i = 0; i < CH_COUNT; i++) begin
            win_cnt[i] = ref_count_q[i*CNT_WIDTH +: CNT_WIDTH];
            in_range[i] = win_cnt[i] >= CNT_WIDTH'(COUNT_MIN) && win_cnt[i] <= CNT_WIDTH'(COUNT_MAX) && win_cnt[i] != CNT_SAT;
            qual_d[i] = !win_q ? qual_q[i] : !in_range[i] ? '0 : qual_q[i] == QW'(QUAL_WINDOWS) ? qual_q[i] : qual_q[i] + QW'(1);
            if (win_q) ch_valid_d[i] = in_range[i] && qual_d[i] == QW'(QUAL_WINDOWS);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH_COUNT; i++) begin
                cnt_q[i]  <= '0;
                qual_q[i] <= '0;
            end
            ref_count_q <= '0;
            ch_valid_q  <= '0;
        end else begin
            for (int i = 0; i < CH_COUNT; i++) begin
                cnt_q[i]  <= cnt_d[i];
                qual_q[i] <= qual_d[i];
            end
            ref_count_q <= ref_count_d;
            ch_valid_q  <= ch_valid_d;
        end
    end

    always_comb begin
        best = '0;
        for (int i = CH_COUNT - 1; i >= 0; i--)
            if (ch_valid_q[i]) best = SW'(i);
    end

    assign valid_pad = NP'(ch_valid_q);
    assign any       = |ch_valid_q;
    assign lost      = sel_valid_q & ~valid_pad[sel_q];

`ifdef REF_CLK_SELECT_FORCE_EN
    logic [SW-1:0] fsel;
    assign fsel = {1'b0, force_sel} >= (SW+1)'(CH_COUNT) ? SW'(CH_COUNT - 1) : force_sel;
`endif

    // Loss of the selected channel outranks holdoff and priority upgrades
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        hold_d      = hold_q;
        if (eval_q) begin
`ifdef REF_CLK_SELECT_FORCE_EN
            if (force_en) begin
                state_d     = S_FORCE;
                sel_d       = fsel;
                sel_valid_d = valid_pad[fsel];
            end else
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (any) begin
                        sel_d       = best;
                        sel_valid_d = 1'b1;
                        hold_d      = HW'(HOLDOFF_WINDOWS);
                        state_d     = S_HOLD;
                    end
                end
                S_ACTIVE, S_HOLD: begin
                    if (lost) begin
                        sel_d       = any ? best : sel_q;
                        sel_valid_d = any;
                        hold_d      = HW'(HOLDOFF_WINDOWS);
                        state_d     = any ? S_HOLD : S_IDLE;
                    end else if (state_q == S_ACTIVE && best < sel_q) begin
                        sel_d   = best;
                        hold_d  = HW'(HOLDOFF_WINDOWS);
                        state_d = S_HOLD;
                    end else if (state_q == S_HOLD) begin
                        hold_d  = hold_q == '0 ? '0 : hold_q - HW'(1);
                        state_d = hold_q <= HW'(1) ? S_ACTIVE : S_HOLD;
                    end
                end
`ifdef REF_CLK_SELECT_FORCE_EN
                S_FORCE: begin
                    hold_d  = HW'(HOLDOFF_WINDOWS);
                    state_d = sel_valid_q ? S_HOLD : S_IDLE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign switch_d = eval_q && (sel_d != sel_q || (sel_valid_d && !sel_valid_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            hold_q      <= '0;
            switch_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            hold_q      <= hold_d;
            switch_q    <= switch_d;
        end
    end

    assign ch_valid     = ch_valid_q;
    assign ref_count    = ref_count_q;
    assign sel          = sel_q;
    assign sel_valid    = sel_valid_q;
    assign switch_pulse = switch_q;
    assign window_pulse = win_q;
endmodule

// File: tb/tb_ref_clk_select.sv
// tb_ref_clk_select: random reference waveforms checked against a per-window behavioural model of ref_clk_select.
// Build with REF_CLK_SELECT_FORCE_EN to exercise the manual override as well.
module tb_ref_clk_select;
    localparam int W = 16;
    localparam int GATE = 100;
    localparam int CMIN = 9;
    localparam int CMAX = 11;
    localparam int QUAL = 2;
    localparam int HOLD = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [1:0]     ref_in = '0;
    logic           force_en = 1'b0;
    logic [0:0]     force_sel = '0;
    logic [1:0]     ch_valid;
    logic [2*W-1:0] ref_count;
    logic [0:0]     sel;
    logic           sel_valid, switch_pulse, window_pulse;

    int n_tests = 0;
    int n_fail = 0;
    int cyc, sw_seen, last_sw, m_sel;
    int acc [2][2];
    int m_last [2];
    int q [2];
    int per [2];
    int ph [2];
    bit prev [2];
    bit [1:0] m_valid;
    bit m_sv, m_sw, m_forced, stop_on_switch;
    int plist [7] = '{0, 8, 9, 10, 10, 11, 12};

    ref_clk_select #(
        .CH_COUNT(2), .GATE_CYCLES(GATE), .CNT_WIDTH(W), .COUNT_MIN(CMIN),
        .COUNT_MAX(CMAX), .QUAL_WINDOWS(QUAL), .HOLDOFF_WINDOWS(HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ref_in(ref_in),
`ifdef REF_CLK_SELECT_FORCE_EN
        .force_en(force_en),
        .force_sel(force_sel),
`endif
        .ch_valid(ch_valid),
        .ref_count(ref_count),
        .sel(sel),
        .sel_valid(sel_valid),
        .switch_pulse(switch_pulse),
        .window_pulse(window_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int best_of(input bit [1:0] v);
        for (int i = 0; i < 2; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    task automatic set_per(input int ch, input int p);
        per[ch] = p;
        ph[ch] = p == 0 ? 0 : int'($urandom_range(0, p - 1));
    endtask

    task automatic model_reset();
        cyc = 0;
        sw_seen = 0;
        last_sw = -100;
        m_sel = 0;
        m_valid = '0;
        m_sv = 0;
        m_sw = 0;
        m_forced = 0;
        stop_on_switch = 0;
        for (int i = 0; i < 2; i++) begin
            acc[0][i] = 0;
            acc[1][i] = 0;
            m_last[i] = 0;
            q[i] = 0;
            prev[i] = 0;
            per[i] = 0;
            ph[i] = 0;
        end
    endtask

    // One window's worth of model: count, qualify, then apply the selection rules
    task automatic process_window();
        int w, old_sel, b;
        bit old_sv, inr;
        w = cyc / GATE - 1;
        for (int i = 0; i < 2; i++) begin
            m_last[i] = acc[w % 2][i];
            acc[w % 2][i] = 0;
            inr = m_last[i] >= CMIN && m_last[i] <= CMAX;
            q[i] = inr ? (q[i] < QUAL ? q[i] + 1 : QUAL) : 0;
            m_valid[i] = q[i] == QUAL;
        end
        old_sel = m_sel;
        old_sv = m_sv;
        b = best_of(m_valid);
        if (force_en) begin
            m_sel = int'(force_sel);
            m_sv = m_valid[m_sel];
            m_forced = 1;
        end else if (m_forced) begin
            m_forced = 0;
            if (m_sv) last_sw = w;
        end else if (!m_sv) begin
            if (m_valid != 0) begin
                m_sel = b;
                m_sv = 1;
                last_sw = w;
            end
        end else if (!m_valid[m_sel]) begin
            if (m_valid != 0) begin
                m_sel = b;
                last_sw = w;
            end else m_sv = 0;
        end else if (w - last_sw > HOLD && b < m_sel) begin
            m_sel = b;
            last_sw = w;
        end
        m_sw = m_sel != old_sel || (m_sv && !old_sv);
        if (stop_on_switch && m_sw && m_sel == 0) begin
            per[0] = 0;
            stop_on_switch = 0;
        end
    endtask

    task automatic step();
        bit v;
        @(posedge clk);
        #1;
        cyc++;
        if (cyc % GATE == 0) process_window();
        check("window_pulse", window_pulse, cyc % GATE == 0);
        check("switch_pulse", switch_pulse, cyc % GATE == 2 && cyc > GATE && m_sw);
        if (switch_pulse) sw_seen++;
        if (cyc % GATE == 0) begin
            check("ref_count0", ref_count[0 +: W], m_last[0]);
            check("ref_count1", ref_count[W +: W], m_last[1]);
        end
        if (cyc % GATE == 1 && cyc > GATE) check("ch_valid", ch_valid, m_valid);
        if (cyc % GATE == 2 && cyc > GATE) begin
            check("sel", sel, m_sel);
            check("sel_valid", sel_valid, m_sv);
        end
        for (int i = 0; i < 2; i++) begin
            v = per[i] != 0 && ph[i] < per[i] / 2;
            if (per[i] != 0) ph[i] = (ph[i] + 1) % per[i];
            if (v && !prev[i]) acc[((cyc + 2) / GATE) % 2][i]++;
            prev[i] = v;
            ref_in[i] = v;
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_windows(input int n);
        run_cycles(n * GATE);
    endtask

    // Called just after a rising clock edge; outputs must clear without waiting for a clock
    task automatic do_reset();
        rst = 1'b1;
        ref_in = '0;
        #1;
        check("rst_ch_valid", ch_valid, 0);
        check("rst_ref_count", ref_count, 0);
        check("rst_sel", sel, 0);
        check("rst_sel_valid", sel_valid, 0);
        check("rst_switch", switch_pulse, 0);
        check("rst_window", window_pulse, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        set_per(1, 10);
        run_cycles(50);
        run_windows(4);
        check("qual_sel", sel, 1);
        check("qual_sel_valid", sel_valid, 1);
        check("qual_ch_valid", ch_valid, 2'b10);
        check("qual_switches", sw_seen, 1);

        set_per(0, 10);
        stop_on_switch = 1;
        run_windows(6);
        check("loss_sel", sel, 1);
        check("loss_ch_valid", ch_valid, 2'b10);
        check("loss_switches", sw_seen, 3);

        do_reset();
        set_per(1, 8);
        run_cycles(50);
        run_windows(5);
        check("oor_ch_valid", ch_valid, 0);
        check("oor_sel_valid", sel_valid, 0);
        check("oor_count", ref_count[W +: W] >= 12 && ref_count[W +: W] <= 13, 1);
        check("oor_switches", sw_seen, 0);

        do_reset();
        set_per(1, 10);
        run_cycles(50);
        do_reset();
        set_per(1, 10);
        run_cycles(150);
        check("requal_early", ch_valid, 0);
        run_windows(1);
        check("requal_done", ch_valid, 2'b10);
        run_windows(1);
        check("requal_sel_valid", sel_valid, 1);

        for (int k = 0; k < 12; k++) begin
            set_per(0, plist[$urandom_range(0, 6)]);
            set_per(1, plist[$urandom_range(0, 6)]);
            run_windows(2);
        end

`ifdef REF_CLK_SELECT_FORCE_EN
        do_reset();
        set_per(0, 10);
        set_per(1, 10);
        run_cycles(50);
        run_windows(4);
        check("force_pre_sel", sel, 0);
        force_en = 1'b1;
        force_sel = 1'b1;
        run_windows(1);
        check("force_sel", sel, 1);
        check("force_sel_valid", sel_valid, 1);
        run_windows(2);
        force_en = 1'b0;
        run_windows(2);
        check("force_hold_sel", sel, 1);
        run_windows(2);
        check("force_return_sel", sel, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ref_clk_select.md
Name: ref_clk_select

Overview:
- Generalised reference-clock monitor and selector for the clock subsystem; supports N candidate reference inputs (internal TCXO, external 10 MHz, backplane, ...).
- Each reference is sampled in the fabric clock domain, and its rising edges are counted over a fixed gate window. A reference is qualified as valid only after enough consecutive in-range windows.
- Drives the select for the downstream clock mux/PLL from a priority rule with switchover holdoff, and reports status to host registers.

Parameters:
CH_COUNT, 2, number of reference inputs (1..8)
GATE_CYCLES, 25000, gate window length in clk cycles
CNT_WIDTH, 16, width of per-channel edge counters
COUNT_MIN, 990, minimum edges per window for an in-range window
COUNT_MAX, 1010, maximum edges per window for an in-range window
QUAL_WINDOWS, 4, consecutive in-range windows required to set channel valid
HOLDOFF_WINDOWS, 2, windows after a switch during which priority-driven switching is suppressed

Ports:
clk  input  1  fabric clock; all logic is in this domain
rst  input  1  asynchronous, active-high reset
ref_in  input  CH_COUNT  raw reference clocks, treated as asynchronous data
ch_valid  output  CH_COUNT  per-channel qualified flag
ref_count  output  CH_COUNT*CNT_WIDTH  last completed window edge count per channel; channel i is at bits [i*CNT_WIDTH +: CNT_WIDTH]
sel  output  max(1,$clog2(CH_COUNT))  selected channel index
sel_valid  output  1  a qualified channel is selected
switch_pulse  output  1  one-cycle strobe when sel changes or sel_valid rises
window_pulse  output  1  one-cycle strobe at each window close

Behaviour:
- Reset domain: rst is asynchronous, active-high; all flops are cleared on rst.
- Reset values: ch_valid=0, ref_count=0, sel=0, sel_valid=0, switch_pulse=0, window_pulse=0. Gate counter, qual counters and holdoff counter are 0; FSM is in IDLE.
- Input path per channel:
  - 2-flop synchroniser, then 1 history flop.
  - A rising edge is (sync=1 and hist=0).
  - Edge detect adds 3 cycles of latency; an edge is counted in the cycle it is detected.
- Gate counter:
  - Counts 0..GATE_CYCLES-1 and wraps.
  - The cycle with count=GATE_CYCLES-1 is the close cycle.
  - An edge detected in the close cycle belongs to the closing window.
- Edge counters saturate at 2^CNT_WIDTH-1 (no wrap). They are cleared in the close cycle, and the next window starts counting from the following cycle.
- At close, each channel's final count is registered into ref_count, and window_pulse=1 one cycle after the close cycle.
- Qualification per channel, evaluated in the cycle after close:
  - In range means COUNT_MIN <= count <= COUNT_MAX, inclusive.
  - In range: qual counter increments, saturating at QUAL_WINDOWS; ch_valid=1 when it reaches QUAL_WINDOWS.
  - Out of range: qual counter=0 and ch_valid=0 in that same cycle.
  - A saturated count is always out of range.
- Priority: the lowest index has the highest priority. best = lowest index with ch_valid=1.
- Selection FSM is evaluated once per window, in the cycle after ch_valid updates (two cycles after close). States:
  - IDLE (sel_valid=0):
    - If any ch_valid: sel=best, sel_valid=1, switch_pulse, holdoff=HOLDOFF_WINDOWS, go to HOLDOFF.
  - ACTIVE:
    - If ch_valid[sel]=0 and any valid: sel=best, switch_pulse, go to HOLDOFF.
    - If ch_valid[sel]=0 and none valid: sel_valid=0, go to IDLE; sel holds its last value.
    - Else if best<sel: sel=best, switch_pulse, go to HOLDOFF.
  - HOLDOFF:
    - Loss of current channel is handled as in ACTIVE and reloads holdoff.
    - Higher-priority candidates are ignored.
    - holdoff decrements each evaluation; at 0, go to ACTIVE.
  - HOLDOFF_WINDOWS=0 means HOLDOFF exits on its first evaluation.
- Simultaneous events: loss of the current channel takes precedence over priority upgrades. With CH_COUNT=1, sel is constant 0.
- Fail-detection latency: worst case 2 windows + 2 cycles from a reference stopping to sel change.
- switch_pulse and window_pulse are exactly 1 cycle wide.

Optional Feature:
REF_CLK_SELECT_FORCE_EN
- Defined:
  - Adds inputs force_en (1 bit) and force_sel (sel width).
  - While force_en=1, at each evaluation sel=force_sel and sel_valid=ch_valid[force_sel]; qualification is unaffected. switch_pulse fires when sel changes.
  - When force_en falls, the FSM enters HOLDOFF if sel_valid=1, else IDLE.
  - force_sel>=CH_COUNT is clamped to CH_COUNT-1.
- Undefined: the ports do not exist, and selection is purely automatic.

Test Plan:
Bench parameters for all scenarios: CH_COUNT=2, GATE_CYCLES=100, COUNT_MIN=9, COUNT_MAX=11, QUAL_WINDOWS=2, HOLDOFF_WINDOWS=2.
1. Qualification: ref_in[1] at period 10 cycles, ref_in[0] idle -> ref_count[1]=10 each window; ch_valid[1]=1 after the 2nd full window; sel=1, sel_valid=1, one switch_pulse.
2. Revertive switch with holdoff: from scenario 1, start ref_in[0] at period 10 -> ch_valid[0] set after 2 windows; sel changes 1->0 at the next evaluation; no further switch for 2 windows.
3. Loss during holdoff: stop ref_in[0] immediately after the switch to 0 -> ch_valid[0]=0 after the next window; sel=1 at that evaluation despite holdoff; switch_pulse=1.
4. Out of range: ref_in[1] at period 8 (12-13 edges per window) -> ch_valid[1] never sets; ref_count shows 12 or 13; sel_valid stays 0.
5. Async reset mid-window: assert rst for 3 cycles at gate count 50 -> all outputs 0 immediately; requalification takes 2 full windows after release.
6. With REF_CLK_SELECT_FORCE_EN: both channels valid, force_en=1, force_sel=1 -> sel=1 at the next evaluation; release force_en -> sel returns to 0 after 2 holdoff windows.
